// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared types and helpers for the programmable Moore sequence detector.
//   state_t   : detector FSM states (HUNT / MATCH)
//   len_width : width of a length field able to hold 0..pat_w
//   clamp_len : maps an out-of-range length (0 or > pat_w) to pat_w
package seq_det_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    MATCH = 1'b1
  } state_t;

  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int clamp_len(input int len, input int pat_w);
    return ((len == 0) || (len > pat_w)) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// seq_window_cmp
// Serial history window with fill tracking and a length-masked pattern compare.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : in_bit is sampled this edge
//   in_bit    : serial bit, shifted in at the history LSB
//   clr       : flush history and fill (pattern reload)
//   flush     : non-overlap mode; a hit restarts the fill from zero
//   pat, len  : active pattern (right-aligned) and its length
//   hit       : combinational; this valid bit completes the pattern
module seq_window_cmp
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = 4,
  localparam int LEN_W = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr,
  input  logic             flush,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] hist_q;
  logic [LEN_W-1:0] fill_q;

  logic [PAT_W:0]   shifted;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_next;

  // NOTE: every signal driven here gets a value before any condition,
  // otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    // Concatenate then truncate so PAT_W = 1 needs no special case.
    shifted   = {hist_q, in_bit};
    hist_next = shifted[PAT_W-1:0];
    fill_next = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    mask      = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = in_valid && (fill_next >= len) && (((hist_next ^ pat) & mask) == '0);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (in_valid) begin
      hist_q <= hist_next;
      fill_q <= (hit && flush) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_moore_param.sv
// seq_detect_moore_param
// Runtime-programmable Moore serial pattern detector with saturating match count.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : in_bit is sampled this edge
//   in_bit      : serial bit; first received bit lines up with the pattern MSB
//   overlap     : 1 = matches may share bits, 0 = each bit used at most once
//   pat_load    : load pat_value/pat_len (drops a coincident valid bit)
//   pat_value   : new pattern, right-aligned
//   pat_len     : new length; 0 or > PAT_W means PAT_W
//   cnt_clr     : clear the match counter (wins over a coincident hit)
//   dout        : Moore match flag, decoded from the state register
//   match_count : saturating number of matches
module seq_detect_moore_param
  import seq_det_pkg::*;
#(
  parameter  int             PAT_W   = 4,
  parameter  int             CNT_W   = 8,
  parameter  logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1101),
  parameter  int             RST_LEN = PAT_W,
  localparam int             LEN_W   = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, PAT_W));

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hit;

  // A pattern load owns the cycle: the coincident bit never reaches the window.
  seq_window_cmp #(.PAT_W(PAT_W)) u_window (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid && !pat_load),
    .in_bit   (in_bit),
    .clr      (pat_load),
    .flush    (!overlap),
    .pat      (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= RST_PAT;
      len_q   <= RST_LEN_C;
      state_q <= HUNT;
      cnt_q   <= '0;
    end else begin
      if (pat_load) begin
        pat_q   <= pat_value;
        len_q   <= LEN_W'(clamp_len(int'(pat_len), PAT_W));
        state_q <= HUNT;
      end else begin
        // MATCH lasts one cycle per hit; idle cycles fall back to HUNT.
        state_q <= hit ? MATCH : HUNT;
      end

      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (hit && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dout        = (state_q == MATCH);
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// tb_seq_detect_moore_param
// Directed bench for seq_detect_moore_param (PAT_W=4, CNT_W=2). Each step drives
// one cycle of inputs and queues the dout/match_count expected after that edge.
module tb_seq_detect_moore_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int LEN_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_value;
  logic [LEN_W-1:0] pat_len;
  logic             cnt_clr;
  logic             dout;
  logic [CNT_W-1:0] match_count;

  typedef struct {
    logic       dout;
    logic [1:0] cnt;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  seq_detect_moore_param #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .overlap     (overlap),
    .pat_load    (pat_load),
    .pat_value   (pat_value),
    .pat_len     (pat_len),
    .cnt_clr     (cnt_clr),
    .dout        (dout),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; expectation is pushed with the stimulus and popped
  // once the edge has happened.
  task automatic step(input logic r, input logic v, input logic b,
                      input logic ld, input logic [3:0] pv, input logic [2:0] pl,
                      input logic c, input logic ed, input logic [1:0] ec,
                      input string tag);
    exp_t e;
    rst       = r;
    in_valid  = v;
    in_bit    = b;
    pat_load  = ld;
    pat_value = pv;
    pat_len   = pl;
    cnt_clr   = c;
    exp_q.push_back('{dout: ed, cnt: ec, tag: tag});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    assert (dout === e.dout) else begin
      bad++;
      $error("FAIL %s dout: observed=%0b expected=%0b", e.tag, dout, e.dout);
    end
    total++;
    assert (match_count === e.cnt) else begin
      bad++;
      $error("FAIL %s count: observed=%0d expected=%0d", e.tag, match_count, e.cnt);
    end
  endtask

  task automatic bit_in(input logic b, input logic ed, input logic [1:0] ec,
                        input string tag);
    step(1'b0, 1'b1, b, 1'b0, 4'h0, 3'd0, 1'b0, ed, ec, tag);
  endtask

  task automatic idle(input logic ed, input logic [1:0] ec, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, ed, ec, tag);
  endtask

  initial begin
    overlap = 1'b1;
    @(negedge clk);

    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, "reset0");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, "reset1");

    // Default pattern 1101, overlap: hits after bits 4 and 7
    bit_in(1'b1, 1'b0, 2'd0, "ov_b1");
    bit_in(1'b1, 1'b0, 2'd0, "ov_b2");
    bit_in(1'b0, 1'b0, 2'd0, "ov_b3");
    bit_in(1'b1, 1'b1, 2'd1, "ov_b4");
    bit_in(1'b1, 1'b0, 2'd1, "ov_b5");
    bit_in(1'b0, 1'b0, 2'd1, "ov_b6");
    bit_in(1'b1, 1'b1, 2'd2, "ov_b7");
    idle(1'b0, 2'd2, "ov_idle");
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 1'b0, 2'd0, "clr");

    // Same stream, non-overlap: single hit after bit 4
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, 3'd4, 1'b0, 1'b0, 2'd0, "load_1101");
    overlap = 1'b0;
    bit_in(1'b1, 1'b0, 2'd0, "no_b1");
    bit_in(1'b1, 1'b0, 2'd0, "no_b2");
    bit_in(1'b0, 1'b0, 2'd0, "no_b3");
    bit_in(1'b1, 1'b1, 2'd1, "no_b4");
    bit_in(1'b1, 1'b0, 2'd1, "no_b5");
    bit_in(1'b0, 1'b0, 2'd1, "no_b6");
    bit_in(1'b1, 1'b0, 2'd1, "no_b7");

    // Pattern 11 len 2, overlap, stream 1111: dout high three cycles
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 3'd2, 1'b1, 1'b0, 2'd0, "load_11");
    bit_in(1'b1, 1'b0, 2'd0, "p11_b1");
    bit_in(1'b1, 1'b1, 2'd1, "p11_b2");
    bit_in(1'b1, 1'b1, 2'd2, "p11_b3");
    bit_in(1'b1, 1'b1, 2'd3, "p11_b4");
    idle(1'b0, 2'd3, "p11_idle");
    // Two more hits: counter saturates at 3
    bit_in(1'b1, 1'b1, 2'd3, "sat_b5");
    bit_in(1'b1, 1'b1, 2'd3, "sat_b6");
    // Clear coincident with a hit: count 0, dout still pulses
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b1, 1'b1, 2'd0, "clr_hit");
    bit_in(1'b1, 1'b1, 2'd1, "after_clr");

    // Gapped 110, then pat_load with a coincident (dropped) valid bit
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, 3'd4, 1'b0, 1'b0, 2'd1, "load_gap");
    bit_in(1'b1, 1'b0, 2'd1, "gap_b1");
    idle(1'b0, 2'd1, "gap_i1");
    bit_in(1'b1, 1'b0, 2'd1, "gap_b2");
    idle(1'b0, 2'd1, "gap_i2");
    bit_in(1'b0, 1'b0, 2'd1, "gap_b3");
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 3'd4, 1'b0, 1'b0, 2'd1, "load_drop");
    bit_in(1'b1, 1'b0, 2'd1, "post_ld_b1");
    bit_in(1'b1, 1'b0, 2'd1, "post_ld_b2");
    bit_in(1'b0, 1'b0, 2'd1, "post_ld_b3");
    bit_in(1'b1, 1'b1, 2'd2, "post_ld_b4");

    // Length 0 clamps to 4: only the full 1101 matches
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, 3'd0, 1'b0, 1'b0, 2'd2, "load_len0");
    bit_in(1'b1, 1'b0, 2'd2, "len0_b1");
    bit_in(1'b1, 1'b0, 2'd2, "len0_b2");
    bit_in(1'b0, 1'b0, 2'd2, "len0_b3");
    bit_in(1'b1, 1'b1, 2'd3, "len0_b4");

    // Pattern 00 len 2, partial 110, reset, then 1101 under restored default
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'd2, 1'b0, 1'b0, 2'd3, "load_00");
    bit_in(1'b1, 1'b0, 2'd3, "rs_b1");
    bit_in(1'b1, 1'b0, 2'd3, "rs_b2");
    bit_in(1'b0, 1'b0, 2'd3, "rs_b3");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, "mid_rst");
    bit_in(1'b1, 1'b0, 2'd0, "rs_after");
    bit_in(1'b1, 1'b0, 2'd0, "def_b2");
    bit_in(1'b0, 1'b0, 2'd0, "def_b3");
    bit_in(1'b1, 1'b1, 2'd1, "def_b4");
    idle(1'b0, 2'd1, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
